wb_mem_slave: RTL and testbench

Wishbone classic responder backed by an on-chip word memory, the target-side counterpart of the core's external-bus initiator. It accepts single read/write cycles with low-aligned byte selects (byte = 4'b0001, half = 4'b0011, word = 4'b1111, data in the low lanes), shifts them to the addressed byte lanes, and answers with a one-cycle acknowledge after a programmable number of wait states. It sits on the system bus as the scratch-RAM / test-memory target.

---
 rtl/wb_pkg.sv | 50 +++++
 rtl/wb_mem_array.sv | 32 +++
 rtl/wb_mem_slave.sv | 170 +++++++++++++++++
 tb/tb_wb_mem_slave.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: byte-select sizes, the responder FSM
// states and lane-shift helpers.
package wb_pkg;

    localparam logic [3:0] WB_SEL_BYTE = 4'b0001;
    localparam logic [3:0] WB_SEL_HALF = 4'b0011;
    localparam logic [3:0] WB_SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic logic [3:0] sel_norm(input logic [3:0] sel);
        if (sel == WB_SEL_BYTE || sel == WB_SEL_HALF) return sel;
        return WB_SEL_WORD;
    endfunction

    // Half ignores addr[0]; word ignores both low bits.
    function automatic logic [1:0] lane_off(
        input logic [3:0] sel,
        input logic [1:0] lo
    );
        if (sel == WB_SEL_BYTE) return lo;
        if (sel == WB_SEL_HALF) return {lo[1], 1'b0};
        return 2'b00;
    endfunction

    function automatic logic [31:0] lane_shl(
        input logic [31:0] d,
        input logic [1:0]  off
    );
        return d << {off, 3'b000};
    endfunction

    function automatic logic [31:0] lane_shr(
        input logic [31:0] d,
        input logic [1:0]  off
    );
        return d >> {off, 3'b000};
    endfunction

    function automatic logic [31:0] size_mask(input logic [3:0] sel);
        if (sel == WB_SEL_BYTE) return 32'h0000_00FF;
        if (sel == WB_SEL_HALF) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

endpackage

// File: rtl/wb_mem_array.sv
// Single-port word RAM: byte-enabled synchronous write, registered read.
module wb_mem_array #(
    parameter int WORDS = 1024,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Read register only moves on reads so the last read value is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (en && !we) rdata <= mem[idx];
    end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic memory responder with programmable wait states.
// Define WB_MEM_SLAVE_ERR_EN to error-terminate out-of-range/misaligned cycles.
module wb_mem_slave
    import wb_pkg::*;
#(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH = WB_DATA_WIDTH / 8,
    parameter int MEM_WORDS = 1024,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int WAIT_STATES = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     wb_ack_o,
    output logic                     wb_err_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam logic [WB_ADDR_WIDTH-1:0] SPAN =
        WB_ADDR_WIDTH'(MEM_WORDS * 4);

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic take, enter;

    logic [WB_ADDR_WIDTH-1:0] req_addr;
    logic                     req_we;
    logic [WB_SEL_WIDTH-1:0]  req_sel;
    logic [WB_DATA_WIDTH-1:0] req_data;

    logic [WB_ADDR_WIDTH-1:0] a_addr, a_rel;
    logic        a_we;
    logic [3:0]  a_sel;
    logic [31:0] a_data;
    logic [1:0]  a_off;
    logic in_range, term_err, drop, mem_en;

    logic [31:0] mem_q;
    logic [1:0]  rd_off;
    logic [3:0]  rd_sel;
    logic        rd_oor;
    logic        ack;

    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        take = 1'b0;
        enter = 1'b0;
        unique case (state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    take = 1'b1;
                    cnt_nxt = WS;
                    if (WS == 4'd0) begin
                        state_nxt = RESP;
                        enter = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_nxt = IDLE;
                    cnt_nxt = '0;
                end else if (cnt <= 4'd1) begin
                    state_nxt = RESP;
                    cnt_nxt = '0;
                    enter = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states the access happens on the capture edge itself.
    assign a_addr = take ? wb_addr_i : req_addr;
    assign a_we   = take ? wb_we_i : req_we;
    assign a_data = take ? wb_data_i : req_data;
    assign a_sel  = sel_norm(take ? wb_sel_i : req_sel);
    assign a_off  = lane_off(a_sel, a_addr[1:0]);
    assign a_rel  = a_addr - BASE_ADDR;
    assign in_range = (a_addr >= BASE_ADDR) && (a_rel < SPAN);

`ifdef WB_MEM_SLAVE_ERR_EN
    logic err;

    assign term_err = !in_range
        || (a_sel == WB_SEL_HALF && a_addr[0])
        || (a_sel == WB_SEL_WORD && a_addr[1:0] != 2'b00);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err <= 1'b0;
        else err <= enter && term_err;
    end

    assign wb_err_o = err;
`else
    assign term_err = 1'b0;
    assign wb_err_o = 1'b0;
`endif

    assign drop = !in_range || term_err;
    assign mem_en = enter && !drop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt <= '0;
            ack <= 1'b0;
            rd_off <= 2'b00;
            rd_sel <= WB_SEL_WORD;
            rd_oor <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            ack <= enter && !term_err;
            if (enter && !a_we && !term_err) begin
                rd_off <= a_off;
                rd_sel <= a_sel;
                rd_oor <= !in_range;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_addr <= '0;
            req_we <= 1'b0;
            req_sel <= '0;
            req_data <= '0;
        end else if (take) begin
            req_addr <= wb_addr_i;
            req_we <= wb_we_i;
            req_sel <= wb_sel_i;
            req_data <= wb_data_i;
        end
    end

    wb_mem_array #(
        .WORDS(MEM_WORDS),
        .IDX_W(IDX_W)
    ) u_array (
        .clk  (clk_i),
        .rst  (rst_i),
        .en   (mem_en),
        .we   (a_we),
        .be   (a_sel << a_off),
        .idx  (a_rel[IDX_W+1:2]),
        .wdata(lane_shl(a_data, a_off)),
        .rdata(mem_q)
    );

    assign wb_data_o = rd_oor ? '0
        : (lane_shr(mem_q, rd_off) & size_mask(rd_sel));
    assign wb_ack_o = ack;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave with a read-data scoreboard queue.
// Builds with or without WB_MEM_SLAVE_ERR_EN.
module tb_wb_mem_slave;

    localparam int WS = 1;
    localparam int WORDS = 64;
`ifdef WB_MEM_SLAVE_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, cyc, stb, we, ack, err;
    logic [31:0] addr, wdat, rdat;
    logic [3:0] sel;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    wb_mem_slave #(
        .MEM_WORDS(WORDS),
        .BASE_ADDR(32'h0),
        .WAIT_STATES(WS)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_addr_i(addr),
        .wb_data_i(wdat),
        .wb_sel_i (sel),
        .wb_data_o(rdat),
        .wb_ack_o (ack),
        .wb_err_o (err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        cyc = 1'b0;
        stb = 1'b0;
        we = 1'b0;
    endtask

    task automatic start(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cyc = 1'b1;
        stb = 1'b1;
        we = w;
        addr = a;
        wdat = d;
        sel = s;
        @(posedge clk);
    endtask

    task automatic wait_term(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(ack || err) && lat < 16);
    endtask

    task automatic xfer(input string tag, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic exp_err,
                        input logic [31:0] exp_rd);
        int lat;
        if (!w) sb.push_back(exp_rd);
        start(w, a, d, s);
        wait_term(lat);
        check({tag, "/lat"}, lat, 1 + WS);
        check({tag, "/ack"}, ack, !exp_err);
        check({tag, "/err"}, err, exp_err);
        if (!w) check({tag, "/data"}, rdat, sb.pop_front());
        idle_bus();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        bit seen;
        rst = 1'b1;
        idle_bus();
        addr = '0;
        wdat = '0;
        sel = '0;
        repeat (2) @(negedge clk);
        check("rst/ack", ack, 0);
        check("rst/err", err, 0);
        check("rst/data", rdat, 0);
        rst = 1'b0;

        xfer("wr10", 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
        xfer("rd10", 0, 32'h10, 0, 4'hF, 0, 32'hDEAD_BEEF);

        xfer("wr4", 1, 32'h4, 32'h1122_3344, 4'hF, 0, 0);
        xfer("wrb6", 1, 32'h6, 32'h0000_00AB, 4'h1, 0, 0);
        check("hold", rdat, 32'hDEAD_BEEF);
        xfer("rd4", 0, 32'h4, 0, 4'hF, 0, 32'h11AB_3344);
        xfer("rdb6", 0, 32'h6, 0, 4'h1, 0, 32'h0000_00AB);
        xfer("rdh6", 0, 32'h6, 0, 4'h3, 0, 32'h0000_11AB);
        xfer("rdb7", 0, 32'h7, 0, 4'h1, 0, 32'h0000_0011);

        // Abort: cyc dropped during the wait state.
        start(1, 32'h10, 32'h5555_5555, 4'hF);
        @(negedge clk);
        idle_bus();
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= ack | err;
        end
        check("abort/noack", seen, 0);
        xfer("rd10b", 0, 32'h10, 0, 4'hF, 0, 32'hDEAD_BEEF);

        xfer("wr0", 1, 32'h0, 32'h0102_0304, 4'hF, 0, 0);
        xfer("rd0", 0, 32'h0, 0, 4'hF, 0, 32'h0102_0304);
        xfer("wroor", 1, WORDS * 4, 32'h5A5A_5A5A, 4'hF, ERR, 0);
        xfer("rdoor", 0, WORDS * 4, 0, 4'hF, ERR,
             ERR ? 32'h0102_0304 : 32'h0);
        xfer("rd0b", 0, 32'h0, 0, 4'hF, 0, 32'h0102_0304);

        xfer("wrh3", 1, 32'h3, 32'h0000_BEEF, 4'h3, ERR, 0);
        xfer("rd0c", 0, 32'h0, 0, 4'hF, 0,
             ERR ? 32'h0102_0304 : 32'hBEEF_0304);
        xfer("rdw5", 0, 32'h5, 0, 4'hF, ERR,
             ERR ? 32'h0102_0304 : 32'h11AB_3344);
        xfer("rdsel5", 0, 32'h4, 0, 4'h5, 0, 32'h11AB_3344);

        // Reset in the middle of a write's wait state.
        start(1, 32'h10, 32'h0, 4'hF);
        #2 rst = 1'b1;
        #1;
        check("rstw/ack", ack, 0);
        check("rstw/err", err, 0);
        check("rstw/data", rdat, 0);
        idle_bus();
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= ack | err;
        end
        check("rstw/noack", seen, 0);
        xfer("rd10c", 0, 32'h10, 0, 4'hF, 0, 32'hDEAD_BEEF);

        // Reset while the acknowledge is high.
        start(0, 32'h4, 0, 4'hF);
        wait_term(lat);
        check("rstr/pre", ack, 1);
        #1 rst = 1'b1;
        #1;
        check("rstr/ack", ack, 0);
        check("rstr/data", rdat, 0);
        idle_bus();
        @(negedge clk);
        rst = 1'b0;

        // stb held through RESP, then back-to-back request.
        sb.push_back(32'hDEAD_BEEF);
        start(0, 32'h10, 0, 4'hF);
        wait_term(lat);
        check("b2b1/lat", lat, 1 + WS);
        check("b2b1/data", rdat, sb.pop_front());
        @(negedge clk);
        check("b2b/noreack", ack, 0);
        sb.push_back(32'h11AB_3344);
        addr = 32'h4;
        @(posedge clk);
        wait_term(lat);
        check("b2b2/lat", lat, 1 + WS);
        check("b2b2/ack", ack, 1);
        check("b2b2/data", rdat, sb.pop_front());
        idle_bus();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
